// File: rtl/pow_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pow_pkg                                                        |
// | Purpose : shared types, defaults and round-robin pick helper             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pow_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_EXPW  = 5;
  localparam int RR_MAX    = 32;

  // First set bit of valid searching upward from last+1, wrapping at nreq.
  // Walking the offsets in reverse lets the nearest candidate win.
  function automatic int rr_pick(input logic [RR_MAX-1:0] valid,
                                 input int nreq,
                                 input int last);
    int idx;
    rr_pick = 0;
    for (int k = nreq; k >= 1; k--) begin
      idx = (last + k) % nreq;
      if (valid[idx[4:0]]) rr_pick = idx;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/pow_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pow_arbiter_if                                                 |
// | Purpose : request/response channel bundle for the shared pow engine      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface pow_arbiter_if import pow_pkg::*; #(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXPW  = DEF_EXPW,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_base;
  logic [NREQ*EXPW-1:0]  req_exp;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  busy;

  modport master (
    output req_valid, req_base, req_exp, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, busy
  );

  modport slave (
    input  req_valid, req_base, req_exp, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, busy
  );

endinterface
`default_nettype wire

// File: rtl/pow_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pow_core                                                       |
// | Purpose : LSB-first square-and-multiply datapath, one exponent bit/cycle |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pow_core import pow_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXPW  = DEF_EXPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] base_in,
  input  logic [EXPW-1:0]  exp_in,
  output logic             last,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [EXPW-1:0]  e_q, e_d;

  always_comb begin
    b_d   = b_q;
    e_d   = e_q;
    acc_d = acc_q;
    if (start) begin
      b_d   = base_in;
      e_d   = exp_in;
      acc_d = {{(WIDTH-1){1'b0}}, 1'b1};
    end else if (step) begin
      if (e_q[0]) acc_d = acc_q * b_q;
      b_d = b_q * b_q;
      e_d = e_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q   <= '0;
      e_q   <= '0;
      acc_q <= '0;
    end else begin
      b_q   <= b_d;
      e_q   <= e_d;
      acc_q <= acc_d;
    end
  end

  // Remaining exponent of 0 or 1 means this step consumes the final bit.
  assign last   = (e_q <= EXPW'(1));
  assign result = acc_q;

endmodule
`default_nettype wire

// File: rtl/pow_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pow_arbiter                                                    |
// | Purpose : round-robin sharing of one pow_core among NREQ requesters      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pow_arbiter import pow_pkg::*; #(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXPW  = DEF_EXPW,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic          clk,
  input  logic          rst,
  pow_arbiter_if.slave  bus
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   grant;
  logic [NREQ-1:0]  ready;
  logic             start;
  logic             step;
  logic             core_last;
  logic [WIDTH-1:0] core_result;
  logic [WIDTH-1:0] base_sel;
  logic [EXPW-1:0]  exp_sel;

  assign grant    = IDW'(rr_pick(RR_MAX'(bus.req_valid), NREQ, int'(last_grant_q)));
  assign base_sel = bus.req_base[int'(grant)*WIDTH +: WIDTH];
  assign exp_sel  = bus.req_exp[int'(grant)*EXPW +: EXPW];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    ready        = '0;
    start        = 1'b0;
    step         = 1'b0;
    case (state_q)
      IDLE: begin
        // The granted requester is valid by construction, so ready implies accept.
        if (|bus.req_valid) begin
          ready        = NREQ'(1) << grant;
          start        = 1'b1;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (core_last) state_d = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      id_q         <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
    end
  end

  pow_core #(
    .WIDTH (WIDTH),
    .EXPW  (EXPW)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .step    (step),
    .base_in (base_sel),
    .exp_in  (exp_sel),
    .last    (core_last),
    .result  (core_result)
  );

  assign bus.req_ready  = ready;
  assign bus.rsp_valid  = (state_q == DONE);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = core_result;
  assign bus.busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pow_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_pow_arbiter                                                 |
// | Purpose : self-checking bench for pow_arbiter against a behavioural model|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pow_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int EXPW  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pow_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .EXPW(EXPW)) bus ();

  pow_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .EXPW(EXPW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NREQ-1:0]  vld;
  logic [WIDTH-1:0] bs [NREQ];
  logic [EXPW-1:0]  ex [NREQ];
  int               last_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: repeated multiplication, truncated to WIDTH.
  function automatic logic [WIDTH-1:0] pow_ref(input logic [WIDTH-1:0] b, input int e);
    logic [WIDTH-1:0] r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic int bitlen(input int e);
    int n;
    n = 0;
    while (e > 0) begin
      n++;
      e = e >> 1;
    end
    return n;
  endfunction

  function automatic int next_grant(input logic [NREQ-1:0] v, input int last);
    int idx;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (last + k) % NREQ;
      if (((v >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_base[i*WIDTH +: WIDTH] = bs[i];
      bus.req_exp[i*EXPW +: EXPW]    = ex[i];
    end
    bus.req_valid = vld;
  endtask

  // One complete operation, entered and left 1 time unit after a posedge in IDLE.
  task automatic op(input int stall, input bit scramble);
    int               g;
    int               lat;
    int               cyc;
    logic [WIDTH-1:0] er;
    drive();
    bus.rsp_ready = (stall == 0);
    #1;
    chk("busy_idle", {63'd0, bus.busy}, 64'd0);
    g = next_grant(vld, last_g);
    chk("grant", {60'd0, bus.req_ready}, (g < 0) ? 64'd0 : (64'd1 << g));
    er     = pow_ref(bs[g], int'(ex[g]));
    lat    = 1 + ((bitlen(int'(ex[g])) > 1) ? bitlen(int'(ex[g])) : 1);
    last_g = g;
    @(posedge clk); #1;
    cyc = 1;
    if (scramble) begin
      bus.req_valid = NREQ'($urandom);
      #1;
    end
    while (bus.rsp_valid !== 1'b1 && cyc < 64) begin
      chk("ready_in_run", {60'd0, bus.req_ready}, 64'd0);
      @(posedge clk); #1;
      cyc++;
    end
    chk("rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    chk("latency", 64'(cyc), 64'(lat));
    chk("result", {32'd0, bus.rsp_result}, {32'd0, er});
    chk("rsp_id", {62'd0, bus.rsp_id}, 64'(g));
    if (stall > 0) bus.req_valid = '1;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("bp_valid", {63'd0, bus.rsp_valid}, 64'd1);
      chk("bp_result", {32'd0, bus.rsp_result}, {32'd0, er});
      chk("bp_id", {62'd0, bus.rsp_id}, 64'(g));
      chk("bp_ready", {60'd0, bus.req_ready}, 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("busy_after", {63'd0, bus.busy}, 64'd0);
    chk("rsp_after", {63'd0, bus.rsp_valid}, 64'd0);
    bus.req_valid = '0;
  endtask

  task automatic set_req(input int r, input logic [WIDTH-1:0] b, input logic [EXPW-1:0] e);
    vld   = NREQ'(1) << r;
    bs[r] = b;
    ex[r] = e;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst    = 1'b0;
    last_g = NREQ - 1;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_base  = '0;
    bus.req_exp   = '0;
    bus.rsp_ready = 1'b0;
    vld           = '0;
    for (int i = 0; i < NREQ; i++) begin
      bs[i] = '0;
      ex[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_rsp_id", {62'd0, bus.rsp_id}, 64'd0);
    chk("rst_result", {32'd0, bus.rsp_result}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_ready", {60'd0, bus.req_ready}, 64'd0);

    // Directed corner cases
    set_req(0, 32'd2, 5'd5);            op(0, 1'b0);
    set_req(2, 32'd7, 5'd0);            op(0, 1'b0);
    set_req(2, 32'd0, 5'd0);            op(0, 1'b0);
    set_req(3, 32'd0, 5'd3);            op(0, 1'b0);
    set_req(1, 32'hFFFF_FFFF, 5'd2);    op(0, 1'b0);
    set_req(1, 32'd2, 5'd31);           op(0, 1'b0);

    // All requesters continuously valid after reset
    do_reset();
    vld = '1;
    for (int i = 0; i < NREQ; i++) begin
      bs[i] = WIDTH'(i + 3);
      ex[i] = EXPW'(i + 1);
    end
    repeat (5) op(0, 1'b0);

    // Response backpressure
    set_req(3, 32'd5, 5'd6);
    op(3, 1'b0);

    // Reset during RUN
    set_req(2, 32'd3, 5'd31);
    drive();
    bus.rsp_ready = 1'b1;
    #1;
    chk("mid_grant", {60'd0, bus.req_ready}, 64'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy_run", {63'd0, bus.busy}, 64'd1);
    bus.req_valid = '0;
    do_reset();
    chk("mid_busy", {63'd0, bus.busy}, 64'd0);
    chk("mid_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("mid_result", {32'd0, bus.rsp_result}, 64'd0);
    vld = '1;
    op(0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      vld = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        bs[i] = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
        ex[i] = EXPW'($urandom);
      end
      op($urandom_range(0, 3), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
